// File: rtl/pri_sel_if.sv
`default_nettype none
// ============================================================================
//  Module   : pri_sel_if
//  Brief    : Request/grant matrix bundle for the pri_sel iSLIP matcher.
//  Revision : 1.0 - initial release
// ============================================================================
interface pri_sel_if #(
  parameter int N = 4
);
  logic [N-1:0][N-1:0] in;
  logic [N-1:0][N-1:0] out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface
`default_nettype wire

// File: rtl/pri_sel.sv
`default_nettype none
// ============================================================================
//  Module   : pri_sel
//  Brief    : Single-iteration iSLIP matcher with per-time-slot pointer banks.
//  Revision : 1.0 - initial release
// ============================================================================
module pri_sel #(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic      clk,
  input  logic      reset,
  pri_sel_if.slave  bus
);

  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
  localparam int SLOT_W = (P > 1) ? $clog2(P) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [N-1:0][N-1:0] out_q, out_d;
  logic [SLOT_W-1:0]   s_q, s_d;
  ptr_t                g_q [P][N];
  ptr_t                g_d [P][N];
  ptr_t                a_q [P][N];
  ptr_t                a_d [P][N];

  // Grants are held column-major: gnt_col[j][i] means output j granted input i.
  logic [N-1:0][N-1:0] gnt_col;
  logic [N-1:0][N-1:0] gnt_row;
  logic [N-1:0][N-1:0] acc;

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input ptr_t ptr);
    logic [N-1:0] pick;
    logic         found;
    int           idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic ptr_t next_ptr(input int k);
    int t;
    t = k + 1;
    if (t >= N) t = 0;
    return t[PTR_W-1:0];
  endfunction

  always_comb begin
    gnt_col = '0;
    gnt_row = '0;
    acc     = '0;
    g_d     = g_q;
    a_d     = a_q;
    s_d     = (s_q == SLOT_W'(P - 1)) ? '0 : s_q + 1'b1;

    for (int j = 0; j < N; j++) begin
      logic [N-1:0] col_req;
      col_req = '0;
      for (int i = 0; i < N; i++) col_req[i] = bus.in[i][j];
      gnt_col[j] = rr_pick(col_req, g_q[s_q][j]);
    end

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) gnt_row[i][j] = gnt_col[j][i];
      acc[i] = rr_pick(gnt_row[i], a_q[s_q][i]);
    end

    // Only accepted pairs move pointers, and only in the active slot's bank.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (acc[i][j]) begin
          g_d[s_q][j] = next_ptr(i);
          a_d[s_q][i] = next_ptr(j);
        end
      end
    end

    out_d = acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      s_q   <= '0;
      for (int k = 0; k < P; k++) begin
        for (int n = 0; n < N; n++) begin
          g_q[k][n] <= '0;
          a_q[k][n] <= '0;
        end
      end
    end else begin
      out_q <= out_d;
      s_q   <= s_d;
      g_q   <= g_d;
      a_q   <= a_d;
    end
  end

  assign bus.out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_pri_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pri_sel
//  Brief    : Directed vector table plus matching-validity sweep for pri_sel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pri_sel;
  localparam int N = 4;
  localparam int P = 8;

  typedef logic [N-1:0][N-1:0] mat_t;
  typedef struct {
    logic  rst;
    mat_t  in_v;
    mat_t  exp_v;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pri_sel_if #(.N(N)) bus();

  pri_sel #(.N(N), .P(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic mat_t m(input logic [3:0] r3, input logic [3:0] r2,
                             input logic [3:0] r1, input logic [3:0] r0);
    return {r3, r2, r1, r0};
  endfunction

  function automatic void add(input logic rst, input mat_t iv, input mat_t ev,
                              input string nm, input int cnt);
    vec_t v;
    v.rst = rst; v.in_v = iv; v.exp_v = ev; v.name = nm;
    for (int k = 0; k < cnt; k++) vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    reset  = v.rst;
    bus.in = v.in_v;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out !== v.exp_v) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h", v.name, bus.out, v.exp_v);
    end
  endtask

  initial begin
    mat_t a_pat, zero, ones;
    a_pat = m(4'b1110, 4'b1110, 4'b1110, 4'b1111);
    zero  = '0;
    ones  = '1;
    reset  = 1'b1;
    bus.in = '0;

    // Reset held with full requests, then fixed pattern across all slots.
    add(1'b1, ones,  zero,                               "reset_hold",   2);
    add(1'b0, a_pat, m(4'b0, 4'b0, 4'b0, 4'b0001),      "slots0_7",     8);
    add(1'b0, a_pat, m(4'b0, 4'b0, 4'b0, 4'b0010),      "slot0_reuse",  1);
    add(1'b0, a_pat, m(4'b0, 4'b0, 4'b0, 4'b0010),      "slot1_reuse",  1);
    // Mid-stream reset must reproduce the power-up sequence exactly.
    add(1'b1, a_pat, zero,                               "mid_reset",    1);
    add(1'b0, a_pat, m(4'b0, 4'b0, 4'b0, 4'b0001),      "re_slots0_7",  8);
    add(1'b0, a_pat, m(4'b0, 4'b0, 4'b0, 4'b0010),      "re_slot0",     1);
    // Single request lands in slot 3; revisit slot 3 to observe its pointers.
    add(1'b1, zero,  zero,                               "reset2",       1);
    add(1'b0, zero,  zero,                               "idle_a",       3);
    add(1'b0, m(4'b0, 4'b0100, 4'b0, 4'b0), m(4'b0, 4'b0100, 4'b0, 4'b0), "single", 1);
    add(1'b0, zero,  zero,                               "idle_b",       7);
    add(1'b0, m(4'b1100, 4'b1100, 4'b0, 4'b0), m(4'b0100, 4'b1000, 4'b0, 4'b0), "slot3_ptr", 1);
    add(1'b0, m(4'b1100, 4'b1100, 4'b0, 4'b0), m(4'b0, 4'b0100, 4'b0, 4'b0), "slot4_clean", 1);
    add(1'b0, zero,  zero,                               "idle_c",       6);
    add(1'b0, m(4'b0100, 4'b1100, 4'b0, 4'b0), m(4'b0, 4'b0100, 4'b0, 4'b0), "slot3_wrap", 1);

    foreach (vecs[k]) apply(vecs[k]);

    // Random matrices: output must be a non-empty matching within last input.
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      mat_t prev;
      logic ok;
      int   cnt;
      prev   = mat_t'($urandom & $urandom);
      bus.in = prev;
      @(posedge clk);
      #1;
      ok = ((bus.out & ~prev) == '0) && ((bus.out != '0) == (prev != '0));
      for (int i = 0; i < N; i++) begin
        if ($countones(bus.out[i]) > 1) ok = 1'b0;
        cnt = 0;
        for (int r = 0; r < N; r++) cnt += int'(bus.out[r][i]);
        if (cnt > 1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_match: in=%h out=%h required=valid matching", prev, bus.out);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pri_sel.md
PRI_SEL -- requirements
Module: pri_sel

Interface
REQ-001 Parameter N, default 4: number of inputs and outputs; request/grant matrix is N x N; N >= 2.
REQ-002 Parameter P, default 8: number of time slots, each with its own round-robin pointer bank; P >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in  input  [N-1:0][N-1:0]  request matrix; in[i][j]=1 means input i requests output j.
REQ-006 out  output  [N-1:0][N-1:0]  registered grant matrix; out[i][j]=1 means input i is matched to output j.

Function
REQ-007 A free-running slot counter s SHALL count 0..P-1 and wrap to 0, advancing by 1 every non-reset cycle.
REQ-008 Each slot k SHALL hold N grant pointers g[k][j] and N accept pointers a[k][i], each ceil(log2 N) bits wide, with range 0..N-1.
REQ-009 Each cycle SHALL perform one iSLIP iteration using the pointer bank of the current slot s.
REQ-010 Grant phase: for each output j, select the requesting input i (in[i][j]=1) first found searching g[s][j], g[s][j]+1, ... mod N; no grant if column j has no requests.
REQ-011 Accept phase: for each input i, among outputs that granted it, accept the one first found searching a[s][i], a[s][i]+1, ... mod N.
REQ-012 The accepted pairs SHALL be registered into out at the clock edge, giving 1-cycle latency from in to out.
REQ-013 out SHALL be a matching at all times: at most one 1 per row, at most one 1 per column, and out[i][j]=1 only if in[i][j]=1 was sampled.
REQ-014 Pointer update SHALL apply only to bank s and only for accepted pairs (i,j): g[s][j] <= (i+1) mod N and a[s][i] <= (j+1) mod N.
REQ-015 Grants that are not accepted SHALL leave their pointers unchanged; banks of other slots SHALL never change.
REQ-016 An all-zero in SHALL produce all-zero out on the next cycle, with no pointer change.
REQ-017 Pointer wrap: a pointer incremented from N-1 SHALL become 0.
REQ-018 The logic SHALL be purely combinational from in and the current bank to the out and pointer registers; there is no handshake.

Reset
REQ-019 While reset=1 at a rising edge: out <= 0, s <= 0, all g and a in all P banks <= 0.
REQ-020 Reset asserted mid-operation SHALL take effect at the next edge and discard all matching history; behaviour after deassertion SHALL be identical to power-up reset.
REQ-021 Out of reset, the first evaluated cycle SHALL use slot 0.

Verification
REQ-022 Reset with in=all ones -> out=0 for every cycle reset=1; all pointers 0 once released.
REQ-023 N=4, P=8 after reset; in[0]=4'b1111, in[1..3]=4'b1110 held -> out[0]=4'b0001, other rows 0, for each of the first 8 cycles (slots 0..7).
REQ-024 Same stimulus, 9th cycle (slot 0 reused with g[0][0]=1, a[0][0]=1) -> out[0]=4'b0010, other rows 0.
REQ-025 in=0 for several cycles, then a single request in[2]=4'b0100 -> out[2]=4'b0100 one cycle later and out=0 otherwise; only g[s][2] and a[s][2] of that slot change, to 3 and 3.
REQ-026 Random request matrices for 10,000 cycles -> every out is a valid matching subset of the previous cycle's in (REQ-013), and no match is lost: an input left unmatched has no request to an unmatched output granted to it.
REQ-027 Assert reset for one cycle mid-stream -> out=0 the following cycle and the stimulus of REQ-023 reproduces its exact results.
